// File: rtl/axi_chan_multicut_if.sv
// Five-channel AXI handshake bundle (AW, W, B, AR, R) carrying flat payload vectors.
// The master drives requests and accepts responses; the slave does the reverse.
interface axi_chan_multicut_if #(
  parameter int unsigned AwWidth = 1,
  parameter int unsigned WWidth  = 1,
  parameter int unsigned BWidth  = 1,
  parameter int unsigned ArWidth = 1,
  parameter int unsigned RWidth  = 1
);
  logic               aw_valid;
  logic               aw_ready;
  logic [AwWidth-1:0] aw;
  logic               w_valid;
  logic               w_ready;
  logic [WWidth-1:0]  w;
  logic               b_valid;
  logic               b_ready;
  logic [BWidth-1:0]  b;
  logic               ar_valid;
  logic               ar_ready;
  logic [ArWidth-1:0] ar;
  logic               r_valid;
  logic               r_ready;
  logic [RWidth-1:0]  r;

  modport master (
    output aw_valid, aw, input aw_ready,
    output w_valid, w, input w_ready,
    input b_valid, b, output b_ready,
    output ar_valid, ar, input ar_ready,
    input r_valid, r, output r_ready
  );

  modport slave (
    input aw_valid, aw, output aw_ready,
    input w_valid, w, output w_ready,
    output b_valid, b, input b_ready,
    input ar_valid, ar, output ar_ready,
    output r_valid, r, input r_ready
  );
endinterface

// File: rtl/axi_chan_multicut.sv
// Per-channel multi-stage AXI register slice: every stage is a 2-entry elastic buffer,
// so neither valid/data nor ready crosses a stage combinationally.

module axi_chan_multicut_stage #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic             empty
);
  logic [Width-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  // Both handshake outputs come from the occupancy register only.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign empty     = (count == 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // NOTE: payload storage has no reset; it is only observed while count says it is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= in_data;
  end
endmodule

module axi_chan_multicut_chain #(
  parameter int unsigned Cuts  = 1,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic             idle
);
  if (Cuts == 0) begin : g_wire
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_data  = in_data;
    assign idle      = 1'b1;
  end else begin : g_stages
    logic [Cuts:0]    valid;
    logic [Cuts:0]    ready;
    logic [Width-1:0] data [Cuts+1];
    logic [Cuts-1:0]  empty;

    assign valid[0]    = in_valid;
    assign in_ready    = ready[0];
    assign data[0]     = in_data;
    assign out_valid   = valid[Cuts];
    assign ready[Cuts] = out_ready;
    assign out_data    = data[Cuts];
    assign idle        = &empty;

    for (genvar k = 0; k < Cuts; k++) begin : g_stage
      axi_chan_multicut_stage #(.Width(Width)) i_stage (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid  (valid[k]),
        .in_ready  (ready[k]),
        .in_data   (data[k]),
        .out_valid (valid[k+1]),
        .out_ready (ready[k+1]),
        .out_data  (data[k+1]),
        .empty     (empty[k])
      );
    end
  end
endmodule

module axi_chan_multicut #(
  parameter int unsigned AwCuts  = 1,
  parameter int unsigned WCuts   = 1,
  parameter int unsigned BCuts   = 1,
  parameter int unsigned ArCuts  = 1,
  parameter int unsigned RCuts   = 1,
  parameter int unsigned AwWidth = 1,
  parameter int unsigned WWidth  = 1,
  parameter int unsigned BWidth  = 1,
  parameter int unsigned ArWidth = 1,
  parameter int unsigned RWidth  = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  axi_chan_multicut_if.slave         slv,
  axi_chan_multicut_if.master        mst,
  output logic                       idle_o
);
  logic aw_idle, w_idle, b_idle, ar_idle, r_idle;

  axi_chan_multicut_chain #(.Cuts(AwCuts), .Width(AwWidth)) i_aw (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .in_valid (slv.aw_valid), .in_ready (slv.aw_ready), .in_data (slv.aw),
    .out_valid (mst.aw_valid), .out_ready (mst.aw_ready), .out_data (mst.aw),
    .idle (aw_idle)
  );

  axi_chan_multicut_chain #(.Cuts(WCuts), .Width(WWidth)) i_w (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .in_valid (slv.w_valid), .in_ready (slv.w_ready), .in_data (slv.w),
    .out_valid (mst.w_valid), .out_ready (mst.w_ready), .out_data (mst.w),
    .idle (w_idle)
  );

  // Response channels run downstream-to-upstream.
  axi_chan_multicut_chain #(.Cuts(BCuts), .Width(BWidth)) i_b (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .in_valid (mst.b_valid), .in_ready (mst.b_ready), .in_data (mst.b),
    .out_valid (slv.b_valid), .out_ready (slv.b_ready), .out_data (slv.b),
    .idle (b_idle)
  );

  axi_chan_multicut_chain #(.Cuts(ArCuts), .Width(ArWidth)) i_ar (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .in_valid (slv.ar_valid), .in_ready (slv.ar_ready), .in_data (slv.ar),
    .out_valid (mst.ar_valid), .out_ready (mst.ar_ready), .out_data (mst.ar),
    .idle (ar_idle)
  );

  axi_chan_multicut_chain #(.Cuts(RCuts), .Width(RWidth)) i_r (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .in_valid (mst.r_valid), .in_ready (mst.r_ready), .in_data (mst.r),
    .out_valid (slv.r_valid), .out_ready (slv.r_ready), .out_data (slv.r),
    .idle (r_idle)
  );

  assign idle_o = aw_idle & w_idle & b_idle & ar_idle & r_idle;
endmodule

// File: tb/tb_axi_chan_multicut.sv
// Directed bench for axi_chan_multicut with AW=0, W=3, B=1, AR=4, R=2 stages.
// Inputs change 1 time unit after the rising edge; outputs are sampled 4 units after it.
module tb_axi_chan_multicut;
  localparam int unsigned Width = 16;

  logic        clk;
  logic        rst_n;
  logic        idle;
  int unsigned n_checks;
  int unsigned n_errors;

  int          sent, rcv, first, last, back;
  int          b_tx, b_rx, r_tx, r_rx;
  bit          b_pending, r_pending, b_stall, r_stall;
  logic [15:0] b_last, r_last;
  logic [15:0] b_exp [$];
  logic [15:0] r_exp [$];

  axi_chan_multicut_if #(.AwWidth(Width), .WWidth(Width), .BWidth(Width),
                         .ArWidth(Width), .RWidth(Width)) slv_bus ();
  axi_chan_multicut_if #(.AwWidth(Width), .WWidth(Width), .BWidth(Width),
                         .ArWidth(Width), .RWidth(Width)) mst_bus ();

  axi_chan_multicut #(
    .AwCuts (0), .WCuts (3), .BCuts (1), .ArCuts (4), .RCuts (2),
    .AwWidth (Width), .WWidth (Width), .BWidth (Width), .ArWidth (Width), .RWidth (Width)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .slv    (slv_bus),
    .mst    (mst_bus),
    .idle_o (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    slv_bus.aw_valid = 1'b0; slv_bus.aw = '0;
    slv_bus.w_valid  = 1'b0; slv_bus.w  = '0;
    slv_bus.ar_valid = 1'b0; slv_bus.ar = '0;
    slv_bus.b_ready  = 1'b1; slv_bus.r_ready = 1'b1;
    mst_bus.aw_ready = 1'b1; mst_bus.w_ready = 1'b1; mst_bus.ar_ready = 1'b1;
    mst_bus.b_valid  = 1'b0; mst_bus.b = '0;
    mst_bus.r_valid  = 1'b0; mst_bus.r = '0;

    // Reset values
    #3;
    check("rst_idle", 32'(idle), 1);
    check("rst_w_valid", 32'(mst_bus.w_valid), 0);
    check("rst_ar_valid", 32'(mst_bus.ar_valid), 0);
    check("rst_b_valid", 32'(slv_bus.b_valid), 0);
    check("rst_r_valid", 32'(slv_bus.r_valid), 0);
    check("rst_w_ready", 32'(slv_bus.w_ready), 1);
    check("rst_ar_ready", 32'(slv_bus.ar_ready), 1);
    check("rst_b_ready", 32'(mst_bus.b_ready), 1);
    check("rst_r_ready", 32'(mst_bus.r_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // AW (wire) and AR (4 stages) presented together
    slv_bus.aw_valid = 1'b1; slv_bus.aw = 16'h0011;
    slv_bus.ar_valid = 1'b1; slv_bus.ar = 16'h0022;
    #3;
    check("aw_pass_valid", 32'(mst_bus.aw_valid), 1);
    check("aw_pass_data", 32'(mst_bus.aw), 32'h11);
    check("ar_not_yet", 32'(mst_bus.ar_valid), 0);
    check("ar_accept_ready", 32'(slv_bus.ar_ready), 1);
    cycle();
    slv_bus.aw_valid = 1'b0; slv_bus.ar_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #3;
      check("ar_latency_valid", 32'(mst_bus.ar_valid), (k == 4) ? 1 : 0);
      check("ar_latency_idle", 32'(idle), 0);
      check("aw_gone", 32'(mst_bus.aw_valid), 0);
      if (k == 4) check("ar_latency_data", 32'(mst_bus.ar), 32'h22);
      cycle();
    end
    #3;
    check("ar_drained_valid", 32'(mst_bus.ar_valid), 0);
    check("ar_drained_idle", 32'(idle), 1);
    cycle();

    // Wire channel passes ready back combinationally
    mst_bus.aw_ready = 1'b0;
    #3;
    check("aw_pass_ready_lo", 32'(slv_bus.aw_ready), 0);
    cycle();
    mst_bus.aw_ready = 1'b1;

    // AR streaming: 20 back-to-back beats, one per cycle after 4 cycles latency
    sent = 0; rcv = 0; first = -1; last = -1;
    for (int c = 0; c < 40 && rcv < 20; c++) begin
      slv_bus.ar_valid = (sent < 20);
      slv_bus.ar = 16'(32'h0400 + sent);
      #3;
      if (mst_bus.ar_valid) begin
        check("ar_stream_data", 32'(mst_bus.ar), 32'(32'h0400 + rcv));
        if (first < 0) first = c;
        last = c;
        rcv++;
      end
      if (slv_bus.ar_valid && slv_bus.ar_ready) sent++;
      cycle();
    end
    slv_bus.ar_valid = 1'b0;
    check("ar_stream_count", rcv, 20);
    check("ar_stream_first", first, 4);
    check("ar_stream_last", last, 23);
    cycle();

    // W backpressure: 3 stages absorb exactly 6 beats
    mst_bus.w_ready = 1'b0;
    slv_bus.w_valid = 1'b1;
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      slv_bus.w = 16'(32'h0100 + sent);
      #3;
      check("w_fill_ready", 32'(slv_bus.w_ready), (c < 6) ? 1 : 0);
      if (slv_bus.w_ready) sent++;
      cycle();
    end
    check("w_fill_count", sent, 6);
    #3;
    check("w_stall_valid", 32'(mst_bus.w_valid), 1);
    check("w_stall_head", 32'(mst_bus.w), 32'h0100);
    cycle();
    slv_bus.w_valid = 1'b0;
    mst_bus.w_ready = 1'b1;
    back = -1;
    for (int k = 0; k < 6; k++) begin
      #3;
      check("w_drain_valid", 32'(mst_bus.w_valid), 1);
      check("w_drain_data", 32'(mst_bus.w), 32'(32'h0100 + k));
      if (back < 0 && slv_bus.w_ready) back = k;
      cycle();
    end
    #3;
    check("w_drain_done", 32'(mst_bus.w_valid), 0);
    check("w_drain_idle", 32'(idle), 1);
    check("w_ready_return", 32'(back >= 0 && back <= 3), 1);
    cycle();

    // Idle tracking through a single W beat
    slv_bus.w_valid = 1'b1; slv_bus.w = 16'h01EE;
    mst_bus.w_ready = 1'b0;
    #3;
    check("idle_accept_cycle", 32'(idle), 1);
    cycle();
    slv_bus.w_valid = 1'b0;
    #3;
    check("idle_fall", 32'(idle), 0);
    cycle();
    cycle();
    #3;
    check("idle_beat_out_valid", 32'(mst_bus.w_valid), 1);
    check("idle_beat_out_data", 32'(mst_bus.w), 32'h01EE);
    check("idle_still_busy", 32'(idle), 0);
    cycle();
    mst_bus.w_ready = 1'b1;
    #3;
    check("idle_handshake_cycle", 32'(idle), 0);
    cycle();
    #3;
    check("idle_rise", 32'(idle), 1);
    check("idle_w_empty", 32'(mst_bus.w_valid), 0);
    cycle();

    // Load 3 beats into R, then reset mid-operation
    slv_bus.r_ready = 1'b0;
    mst_bus.r_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mst_bus.r = 16'(32'h0300 + k);
      #3;
      check("r_load_ready", 32'(mst_bus.r_ready), 1);
      cycle();
    end
    mst_bus.r_valid = 1'b0;
    #3;
    check("r_loaded_valid", 32'(slv_bus.r_valid), 1);
    check("r_loaded_head", 32'(slv_bus.r), 32'h0300);
    check("r_loaded_idle", 32'(idle), 0);
    cycle();
    rst_n = 1'b0;
    #1;
    check("r_rst_valid", 32'(slv_bus.r_valid), 0);
    check("r_rst_idle", 32'(idle), 1);
    check("r_rst_ready", 32'(mst_bus.r_ready), 1);
    cycle();
    #3;
    rst_n = 1'b1;
    cycle();
    slv_bus.r_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #3;
      check("r_no_stale_valid", 32'(slv_bus.r_valid), 0);
      check("r_no_stale_idle", 32'(idle), 1);
      cycle();
    end

    // B and R with random valids and random readies: order, no loss, stability
    b_tx = 0; b_rx = 0; r_tx = 0; r_rx = 0;
    b_pending = 1'b0; r_pending = 1'b0; b_stall = 1'b0; r_stall = 1'b0;
    b_last = '0; r_last = '0;
    for (int c = 0; c < 20000 && (b_rx < 500 || r_rx < 500); c++) begin
      if (!b_pending) begin
        mst_bus.b_valid = (b_tx < 500) && ($urandom_range(1, 0) == 1);
        mst_bus.b = 16'(32'h5000 + b_tx);
      end
      if (!r_pending) begin
        mst_bus.r_valid = (r_tx < 500) && ($urandom_range(1, 0) == 1);
        mst_bus.r = 16'(32'h6000 + r_tx);
      end
      slv_bus.b_ready = ($urandom_range(1, 0) == 1);
      slv_bus.r_ready = ($urandom_range(1, 0) == 1);
      #3;
      if (mst_bus.b_valid && mst_bus.b_ready) begin
        b_exp.push_back(16'(32'h5000 + b_tx));
        b_tx++;
        b_pending = 1'b0;
      end else begin
        b_pending = mst_bus.b_valid;
      end
      if (mst_bus.r_valid && mst_bus.r_ready) begin
        r_exp.push_back(16'(32'h6000 + r_tx));
        r_tx++;
        r_pending = 1'b0;
      end else begin
        r_pending = mst_bus.r_valid;
      end
      if (b_stall) begin
        check("b_hold_valid", 32'(slv_bus.b_valid), 1);
        check("b_hold_data", 32'(slv_bus.b), 32'(b_last));
      end
      if (r_stall) begin
        check("r_hold_valid", 32'(slv_bus.r_valid), 1);
        check("r_hold_data", 32'(slv_bus.r), 32'(r_last));
      end
      if (slv_bus.b_valid && slv_bus.b_ready) begin
        if (b_exp.size() == 0) check("b_unexpected", 32'(b_exp.size()), 1);
        else check("b_order", 32'(slv_bus.b), 32'(b_exp.pop_front()));
        b_rx++;
      end
      if (slv_bus.r_valid && slv_bus.r_ready) begin
        if (r_exp.size() == 0) check("r_unexpected", 32'(r_exp.size()), 1);
        else check("r_order", 32'(slv_bus.r), 32'(r_exp.pop_front()));
        r_rx++;
      end
      b_stall = slv_bus.b_valid && !slv_bus.b_ready;
      r_stall = slv_bus.r_valid && !slv_bus.r_ready;
      b_last  = slv_bus.b;
      r_last  = slv_bus.r;
      cycle();
    end
    mst_bus.b_valid = 1'b0;
    mst_bus.r_valid = 1'b0;
    slv_bus.b_ready = 1'b1;
    slv_bus.r_ready = 1'b1;
    check("b_rx_count", b_rx, 500);
    check("r_rx_count", r_rx, 500);
    check("b_left_over", 32'(b_exp.size()), 0);
    check("r_left_over", 32'(r_exp.size()), 0);
    #3;
    check("final_idle", 32'(idle), 1);
    check("final_b_valid", 32'(slv_bus.b_valid), 0);
    check("final_r_valid", 32'(slv_bus.r_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
